// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART command sequencer.
// Holds the FSM state encoding, the opcode values and the frame header size.
package uart_alu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RSVD,
    LEN_LO,
    LEN_HI,
    ECHO,
    ACC,
    RESP,
    DRAIN
  } state_t;

  localparam logic [7:0] OP_ECHO   = 8'hEC;
  localparam logic [7:0] OP_ADD    = 8'hA0;
  localparam int         HDR_BYTES = 4;

endpackage

// File: rtl/uart_alu_acc.sv
// Operand assembler and accumulator for the ADD command.
// Bytes arrive LSB first; each completed operand loads or adds into the accumulator.
module uart_alu_acc #(
  parameter int DATA_WIDTH = 8,
  parameter int OPER_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  byte_stb,
  input  logic [DATA_WIDTH-1:0] byte_data,
  output logic                  oper_done,
  output logic [OPER_WIDTH-1:0] acc
);

  localparam int NB = OPER_WIDTH / DATA_WIDTH;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  logic [IW-1:0]         idx;
  logic [OPER_WIDTH-1:0] shreg;
  logic [OPER_WIDTH-1:0] operand;
  logic                  first_oper;

  // The newest byte enters at the top, so after NB shifts byte 0 sits at the LSB.
  assign operand   = {byte_data, shreg[OPER_WIDTH-1:DATA_WIDTH]};
  assign oper_done = byte_stb && (idx == IW'(NB - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      shreg      <= '0;
      acc        <= '0;
      first_oper <= 1'b1;
    end else if (clear) begin
      idx        <= '0;
      shreg      <= '0;
      first_oper <= 1'b1;
    end else if (byte_stb) begin
      shreg <= operand;
      idx   <= oper_done ? '0 : idx + IW'(1);
      if (oper_done) begin
        acc        <= first_oper ? operand : acc + operand;
        first_oper <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_alu_ctrl.sv
// Command sequencer between the UART RX/TX byte streams and the ADD accumulator.
// Parses framed commands, echoes payloads or returns 32-bit sums LSB first.
module uart_alu_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int OPER_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] rx_tdata_i,
  input  logic                  rx_tvalid_i,
  output logic                  rx_tready_o,
  output logic [DATA_WIDTH-1:0] tx_tdata_o,
  output logic                  tx_tvalid_o,
  input  logic                  tx_tready_i,
  output logic                  busy_o,
  output logic                  err_o
);

  import uart_alu_pkg::*;

  localparam int NB = OPER_WIDTH / DATA_WIDTH;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  state_t                  state, state_n;
  logic [DATA_WIDTH-1:0]   opcode;
  logic [DATA_WIDTH-1:0]   len_lo;
  logic [LEN_WIDTH-1:0]    count;
  logic [LEN_WIDTH-1:0]    len_full;
  logic [LEN_WIDTH-1:0]    remaining;
  logic [IW-1:0]           resp_idx;
  logic                    err_q;
  logic                    err_set;
  logic                    count_load;
  logic                    count_dec;
  logic                    acc_clear;
  logic                    acc_stb;
  logic                    oper_done;
  logic                    ready_st;
  logic [OPER_WIDTH-1:0]   acc_val;

  assign len_full  = LEN_WIDTH'({rx_tdata_i, len_lo});
  assign remaining = len_full - LEN_WIDTH'(HDR_BYTES);
  assign acc_stb   = (state == ACC) && rx_tvalid_i;
  assign busy_o    = (state != IDLE);
  assign err_o     = err_q;
  // Ready is forced low during reset even though IDLE otherwise accepts.
  assign rx_tready_o = ready_st && !rst_i;

  uart_alu_acc #(
    .DATA_WIDTH(DATA_WIDTH),
    .OPER_WIDTH(OPER_WIDTH)
  ) u_acc (
    .clk      (clk_i),
    .rst      (rst_i),
    .clear    (acc_clear),
    .byte_stb (acc_stb),
    .byte_data(rx_tdata_i),
    .oper_done(oper_done),
    .acc      (acc_val)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    ready_st    = 1'b0;
    tx_tvalid_o = 1'b0;
    tx_tdata_o  = '0;
    err_set     = 1'b0;
    count_load  = 1'b0;
    count_dec   = 1'b0;
    acc_clear   = 1'b0;
    case (state)
      IDLE: begin
        ready_st = 1'b1;
        if (rx_tvalid_i) state_n = RSVD;
      end
      RSVD: begin
        ready_st = 1'b1;
        if (rx_tvalid_i) state_n = LEN_LO;
      end
      LEN_LO: begin
        ready_st = 1'b1;
        if (rx_tvalid_i) state_n = LEN_HI;
      end
      // Whole-frame validation happens here, on the len_hi handshake.
      LEN_HI: begin
        ready_st = 1'b1;
        if (rx_tvalid_i) begin
          count_load = 1'b1;
          state_n    = IDLE;
          if (len_full < LEN_WIDTH'(HDR_BYTES)) begin
            err_set = 1'b1;
          end else if (opcode == OP_ECHO) begin
            if (remaining != '0) state_n = ECHO;
          end else if (opcode == OP_ADD && remaining != '0 && remaining[IW-1:0] == '0) begin
            state_n   = ACC;
            acc_clear = 1'b1;
          end else begin
            err_set = 1'b1;
            if (remaining != '0) state_n = DRAIN;
          end
        end
      end
      ECHO: begin
        ready_st    = tx_tready_i;
        tx_tvalid_o = rx_tvalid_i;
        tx_tdata_o  = rx_tdata_i;
        if (rx_tvalid_i && tx_tready_i) begin
          count_dec = 1'b1;
          if (count == LEN_WIDTH'(1)) state_n = IDLE;
        end
      end
      ACC: begin
        ready_st = 1'b1;
        if (rx_tvalid_i) begin
          count_dec = 1'b1;
          if (oper_done && count == LEN_WIDTH'(1)) state_n = RESP;
        end
      end
      RESP: begin
        tx_tvalid_o = 1'b1;
        tx_tdata_o  = acc_val[resp_idx*DATA_WIDTH +: DATA_WIDTH];
        if (tx_tready_i && resp_idx == IW'(NB - 1)) state_n = IDLE;
      end
      DRAIN: begin
        ready_st = 1'b1;
        if (rx_tvalid_i) begin
          count_dec = 1'b1;
          if (count == LEN_WIDTH'(1)) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      opcode   <= '0;
      len_lo   <= '0;
      count    <= '0;
      resp_idx <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= err_set;
      if (state == IDLE && rx_tvalid_i)   opcode <= rx_tdata_i;
      if (state == LEN_LO && rx_tvalid_i) len_lo <= rx_tdata_i;
      if (count_load)     count <= remaining;
      else if (count_dec) count <= count - LEN_WIDTH'(1);
      if (state != RESP)      resp_idx <= '0;
      else if (tx_tready_i)   resp_idx <= resp_idx + IW'(1);
    end
  end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Self-checking bench for uart_alu_ctrl: directed frame table, timing sequences
// and random frame streams compared against a frame-level reference model.
module tb_uart_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_tdata = 8'h00;
  logic       rx_tvalid = 1'b0;
  logic       rx_tready;
  logic [7:0] tx_tdata;
  logic       tx_tvalid;
  logic       tx_tready = 1'b0;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  logic [7:0] stim_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         err_cnt = 0;
  int         exp_err = 0;
  bit         ready_random = 1'b0;
  bit         valid_random = 1'b0;
  bit         hs_rx = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  typedef struct {
    string        name;
    logic [127:0] frm;
    int           nf;
    logic [31:0]  rsp;
    int           nr;
    int           errs;
  } vec_t;

  vec_t vecs[9];

  uart_alu_ctrl #(
    .DATA_WIDTH(8),
    .OPER_WIDTH(32),
    .LEN_WIDTH (16)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rx_tdata_i (rx_tdata),
    .rx_tvalid_i(rx_tvalid),
    .rx_tready_o(rx_tready),
    .tx_tdata_o (tx_tdata),
    .tx_tvalid_o(tx_tvalid),
    .tx_tready_i(tx_tready),
    .busy_o     (busy),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input string name, input logic [127:0] frm, input int nf,
                              input logic [31:0] rsp, input int nr, input int errs);
    vec_t v;
    v.name = name; v.frm = frm; v.nf = nf; v.rsp = rsp; v.nr = nr; v.errs = errs;
    return v;
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // One clock cycle: drive at the falling edge, observe just before the rising edge.
  task automatic step();
    @(negedge clk);
    if (!(rx_tvalid && !hs_rx)) begin
      if (rx_q.size() > 0 && (!valid_random || $urandom_range(0, 3) != 0)) begin
        rx_tvalid = 1'b1;
        rx_tdata  = rx_q[0];
      end else begin
        rx_tvalid = 1'b0;
      end
    end
    tx_tready = ready_random ? 1'($urandom_range(0, 1)) : 1'b1;
    #4;
    hs_rx = rx_tvalid && rx_tready;
    if (hs_rx) void'(rx_q.pop_front());
    if (prev_stall && tx_tvalid) checkOutput("tx_hold", tx_tdata, prev_data);
    prev_stall = tx_tvalid && !tx_tready;
    prev_data  = tx_tdata;
    if (tx_tvalid && tx_tready) got_q.push_back(tx_tdata);
    if (err) err_cnt++;
  endtask

  task automatic doReset();
    rst = 1'b1;
    rx_tvalid = 1'b0;
    rx_q.delete();
    hs_rx = 1'b0;
    prev_stall = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input string name);
    int n;
    n = 0;
    got_q.delete();
    err_cnt = 0;
    rx_q = stim_q;
    do begin
      step();
      n++;
    end while ((rx_q.size() > 0 || busy) && n < 20000);
    if (n >= 20000) begin
      checkOutput({name, " timeout"}, 1, 0);
      doReset();
    end
  endtask

  task automatic compareResults(input string name);
    checkOutput({name, " tx_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      checkOutput({name, " tx_byte"}, got_q[i], exp_q[i]);
    checkOutput({name, " err_count"}, err_cnt, exp_err);
  endtask

  // Frame-level reference: walk the byte stream frame by frame.
  function automatic void model();
    int i, len, rem;
    int unsigned sum, word;
    exp_q.delete();
    exp_err = 0;
    i = 0;
    while (i + 4 <= stim_q.size()) begin
      len = int'(stim_q[i+2]) + 256 * int'(stim_q[i+3]);
      if (len < 4) begin
        exp_err++;
        i += 4;
        continue;
      end
      rem = len - 4;
      if (stim_q[i] == 8'hEC) begin
        for (int k = 0; k < rem; k++) exp_q.push_back(stim_q[i+4+k]);
      end else if (stim_q[i] == 8'hA0 && rem > 0 && rem % 4 == 0) begin
        sum = 0;
        for (int w = 0; w < rem / 4; w++) begin
          word = 0;
          for (int b = 0; b < 4; b++) word += int'(stim_q[i+4+4*w+b]) << (8 * b);
          sum += word;
        end
        for (int b = 0; b < 4; b++) exp_q.push_back(8'((sum >> (8 * b)) & 255));
      end else begin
        exp_err++;
      end
      i += len;
    end
  endfunction

  task automatic genFrame(input int kind);
    logic [7:0] op;
    int rem;
    rem = 0;
    op = 8'($urandom_range(0, 255));
    case (kind)
      0: begin op = 8'hA0; rem = 4 * $urandom_range(1, 4); end
      1: begin op = 8'hEC; rem = $urandom_range(0, 10); end
      2: begin
        if (op == 8'hEC || op == 8'hA0) op = 8'h11;
        rem = $urandom_range(0, 6);
      end
      3: begin
        op = 8'hA0;
        rem = $urandom_range(0, 9);
        if (rem % 4 == 0 && rem != 0) rem++;
      end
      default: begin
        stim_q.push_back(op);
        stim_q.push_back(8'($urandom_range(0, 255)));
        stim_q.push_back(8'($urandom_range(0, 3)));
        stim_q.push_back(8'h00);
        return;
      end
    endcase
    stim_q.push_back(op);
    stim_q.push_back(8'($urandom_range(0, 255)));
    stim_q.push_back(8'((rem + 4) & 255));
    stim_q.push_back(8'((rem + 4) >> 8));
    for (int k = 0; k < rem; k++) stim_q.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    vecs[0] = mk("add",           128'hA0000C00_01000000_02000000, 12, 32'h03000000, 4, 0);
    vecs[1] = mk("add_wrap",      128'hA0000C00_FFFFFFFF_02000000, 12, 32'h01000000, 4, 0);
    vecs[2] = mk("echo_stall",    128'hEC000700_414243, 7, 32'h00414243, 3, 0);
    vecs[3] = mk("bad_op",        128'h55000600_AABB_A0000800_05000000, 14, 32'h05000000, 4, 1);
    vecs[4] = mk("bad_len_drain", 128'hA0000600_1122, 6, 32'h0, 0, 1);
    vecs[5] = mk("short_len",     128'hA0000200_EC000500_77, 9, 32'h00000077, 1, 1);
    vecs[6] = mk("echo_empty",    128'hEC000400, 4, 32'h0, 0, 0);
    vecs[7] = mk("add_empty",     128'hA0000400, 4, 32'h0, 0, 1);
    vecs[8] = mk("add3",          128'hA0001000_10000000_20000000_30000000, 16, 32'h60000000, 4, 0);

    #12;
    checkOutput("rst rx_tready", rx_tready, 0);
    checkOutput("rst tx_tvalid", tx_tvalid, 0);
    checkOutput("rst tx_tdata", tx_tdata, 0);
    checkOutput("rst busy", busy, 0);
    checkOutput("rst err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    #4;
    checkOutput("rx_tready after release", rx_tready, 1);

    ready_random = 1'b1;
    valid_random = 1'b1;
    for (int v = 0; v < 9; v++) begin
      stim_q.delete();
      exp_q.delete();
      for (int k = 0; k < vecs[v].nf; k++) stim_q.push_back(vecs[v].frm[8*(vecs[v].nf-1-k) +: 8]);
      for (int k = 0; k < vecs[v].nr; k++) exp_q.push_back(vecs[v].rsp[8*(vecs[v].nr-1-k) +: 8]);
      exp_err = vecs[v].errs;
      applyStimulus(vecs[v].name);
      compareResults(vecs[v].name);
    end

    // ADD result latency at full rate.
    ready_random = 1'b0;
    valid_random = 1'b0;
    got_q.delete();
    rx_q = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    n = 0;
    while (rx_q.size() > 0 && n < 100) begin step(); n++; end
    step();
    checkOutput("lat tx_tvalid N+1", tx_tvalid, 1);
    checkOutput("lat tx_tdata N+1", tx_tdata, 8'h03);
    step(); step(); step();
    checkOutput("lat busy N+4", busy, 1);
    step();
    checkOutput("lat busy N+5", busy, 0);
    checkOutput("lat tx_tvalid N+5", tx_tvalid, 0);
    checkOutput("lat tx_count", got_q.size(), 4);

    // err_o pulses exactly once, the cycle after len_hi.
    err_cnt = 0;
    rx_q = '{8'h55, 8'h00, 8'h04, 8'h00};
    n = 0;
    while (rx_q.size() > 0 && n < 100) begin step(); n++; end
    checkOutput("err before pulse", err, 0);
    step();
    checkOutput("err pulse", err, 1);
    step();
    checkOutput("err pulse width", err, 0);

    // Reset in the middle of a response.
    got_q.delete();
    rx_q = '{8'hA0, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    n = 0;
    while (rx_q.size() > 0 && n < 100) begin step(); n++; end
    step();
    checkOutput("mid_resp byte0", tx_tdata, 8'h78);
    step();
    checkOutput("mid_resp byte1", tx_tdata, 8'h56);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_resp rst tx_tvalid", tx_tvalid, 0);
    checkOutput("mid_resp rst rx_tready", rx_tready, 0);
    checkOutput("mid_resp rst busy", busy, 0);
    rx_tvalid = 1'b0;
    rx_q.delete();
    hs_rx = 1'b0;
    prev_stall = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stim_q = '{8'hA0, 8'h00, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    exp_q  = '{8'h05, 8'h00, 8'h00, 8'h00};
    exp_err = 0;
    applyStimulus("post_reset_add");
    compareResults("post_reset_add");

    // Random back-to-back frame streams against the reference model.
    ready_random = 1'b1;
    valid_random = 1'b1;
    for (int b = 0; b < 8; b++) begin
      stim_q.delete();
      for (int f = 0; f < 6; f++) genFrame($urandom_range(0, 4));
      model();
      applyStimulus("random");
      compareResults("random");
    end

    // Long ECHO exercising the high length byte.
    stim_q = '{8'hEC, 8'h00, 8'h04, 8'h01};
    for (int k = 0; k < 256; k++) stim_q.push_back(8'($urandom_range(0, 255)));
    model();
    applyStimulus("long_echo");
    compareResults("long_echo");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_alu_ctrl.md
# uart_alu_ctrl

Command sequencer between the UART byte streams and the ALU datapath. It parses framed commands arriving on the UART receive AXI-stream, accumulates 32-bit operands or echoes payload, and returns results on the UART transmit AXI-stream. It sits between the `uart` wrapper's `m_axis_*` output and `s_axis_*` input, as the only consumer and producer of UART traffic.

## Interface
- `DATA_WIDTH`, 8: stream byte width. Only 8 is supported.
- `OPER_WIDTH`, 32: operand/accumulator width. Must be a multiple of `DATA_WIDTH`.
- `LEN_WIDTH`, 16: frame length field width.
- `clk_i` in 1: single clock for the whole block.
- `rst_i` in 1: reset, asynchronous and active-high.
- `rx_tdata_i` in `DATA_WIDTH`: received byte, from UART `m_axis_tdata`.
- `rx_tvalid_i` in 1: received byte valid.
- `rx_tready_o` out 1: block accepts the received byte.
- `tx_tdata_o` out `DATA_WIDTH`: byte to transmit, to UART `s_axis_tdata`.
- `tx_tvalid_o` out 1: transmit byte valid.
- `tx_tready_i` in 1: UART transmitter ready.
- `busy_o` out 1: high whenever the state is not IDLE.
- `err_o` out 1: one-cycle pulse on any framing or opcode error.

## Operation
- **Frame format:** opcode, reserved byte, len_lo, len_hi, then payload.
  - len is the total frame byte count, including the 4-byte header.
  - Payload bytes remaining = len − 4, held in a `LEN_WIDTH` down-counter.
- **Opcodes:**
  - 0xEC ECHO: payload is returned byte for byte.
  - 0xA0 ADD: payload is N little-endian 32-bit operands. Result is their sum modulo 2^32, returned as 4 bytes, LSB first.
- **States:**
  - IDLE → RSVD → LEN_LO → LEN_HI: one accepted byte per transition.
  - After LEN_HI:
    - len < 4: pulse `err_o`, go to IDLE.
    - Unknown opcode: pulse `err_o`. Go to DRAIN, or to IDLE if remaining is 0.
    - ECHO with remaining 0: go to IDLE with no output.
    - ECHO otherwise: go to ECHO.
    - ADD with remaining 0 or remaining mod 4 ≠ 0: pulse `err_o`, go to DRAIN (IDLE if remaining is 0).
    - ADD otherwise: go to ACC.
  - ECHO: pure pass-through.
    - `tx_tdata_o` = `rx_tdata_i`; `tx_tvalid_o` = `rx_tvalid_i`; `rx_tready_o` = `tx_tready_i`.
    - Count decrements on each handshake; go to IDLE after the last byte.
  - ACC:
    - Bytes shift into an operand assembler, LSB first.
    - On every 4th byte the accumulator takes acc + operand. The first operand of a frame loads the accumulator instead of adding.
    - The last operand's handshake goes to RESP.
  - RESP:
    - Sends the 4 result bytes, LSB first, each advancing on `tx_tvalid_o` & `tx_tready_i`.
    - After byte 3 is accepted, go to IDLE.
  - DRAIN: accepts and discards the remaining count, then goes to IDLE.
- **`rx_tready_o` by state:**
  - 1 in IDLE, RSVD, LEN_LO, LEN_HI, ACC and DRAIN.
  - 0 in RESP.
  - Equals `tx_tready_i` in ECHO.
- **`tx_tvalid_o` by state:** registered and high only in RESP; pass-through in ECHO; 0 elsewhere.
- **Reserved byte:** ignored.
- **Length width:** `LEN_WIDTH` arithmetic is unsigned; len = 0xFFFF is legal.

## Timing
- **Reset values:**
  - State is IDLE; accumulator and counters are 0.
  - `tx_tvalid_o` = 0, `tx_tdata_o` = 0, `busy_o` = 0, `err_o` = 0.
  - `rx_tready_o` = 0 while `rst_i` is high, then 1 in the first cycle after release.
- **Reset mid-frame:** `rst_i` asserted mid-frame (including mid-RESP) drops `tx_tvalid_o` immediately and discards the frame.
- **Byte rate:** one header byte per cycle at full rate; no bubbles between frames.
- **ADD latency:**
  - Last operand accepted in cycle N; `tx_tvalid_o` = 1 with result byte 0 in cycle N+1.
  - With `tx_tready_i` held high, result bytes go out in N+1..N+4 and IDLE is re-entered at N+5.
- **RESP stall:** `tx_tdata_o` stays stable while `tx_tvalid_o` is high and `tx_tready_i` is low.
- **`err_o` timing:** asserted in the cycle after the len_hi handshake.
- **ECHO path:** has zero latency; the combinational paths are limited to the ECHO mux.

## Structure
- **Package `uart_alu_pkg`:**
  - State enum: IDLE, RSVD, LEN_LO, LEN_HI, ECHO, ACC, RESP, DRAIN.
  - Opcode localparams: OP_ECHO = 8'hEC, OP_ADD = 8'hA0.
  - HDR_BYTES = 4.
- **Sub-module `uart_alu_acc`:**
  - Contains the byte assembler, 2-bit byte index and `OPER_WIDTH` accumulator.
  - Inputs: clear, byte strobe, byte data.
  - Outputs: operand-complete strobe and accumulator value.

## Test plan
- **ADD:** A0 00 0C 00 01 00 00 00 02 00 00 00 → TX 03 00 00 00; `busy_o` falls after the 4th TX handshake.
- **ADD wrap:** A0 00 0C 00 FF FF FF FF 02 00 00 00 → TX 01 00 00 00; no `err_o`.
- **ECHO with stalls:** EC 00 07 00 41 42 43, with `tx_tready_i` toggling → TX exactly 41 42 43 in order, no loss or duplication.
- **Bad opcode:** 55 00 06 00 AA BB → one `err_o` pulse, no TX, both payload bytes drained. A following ADD frame returns a correct result.
- **Bad length:**
  - A0 00 06 00 11 22 → `err_o`, drain, IDLE.
  - A0 00 02 00 → `err_o`, immediate IDLE; the next byte is treated as an opcode.
- **Reset mid-RESP:** assert `rst_i` after result byte 1 is accepted → `tx_tvalid_o` = 0 at once. After release, A0 00 08 00 05 00 00 00 → TX 05 00 00 00.
